// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register. Drives the 4 KB data memory, screens each access for
// misalignment and range faults, and keeps sticky fault state and saturating access counters.
module ex_mem_stage #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [31:0]      ex_alu_out,
    input  logic [31:0]      ex_wdata,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_memwrite,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic             err_clr,
    output logic [9:0]       dm_addr,
    output logic [31:0]      dm_din,
    output logic             dm_we,
    output logic             mem_valid,
    output logic [31:0]      mem_alu_out,
    output logic [4:0]       mem_rd,
    output logic             mem_regwrite,
    output logic             mem_memtoreg,
    output logic             mem_memread,
    output logic             err,
    output logic [31:0]      err_addr,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] st_cnt
);

    logic             valid_q, valid_d;
    logic [31:0]      alu_q, alu_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [4:0]       rd_q, rd_d;
    logic             regwrite_q, regwrite_d;
    logic             memtoreg_q, memtoreg_d;
    logic             memread_q, memread_d;
    logic             memwrite_q, memwrite_d;
    logic             err_q, err_d;
    logic [31:0]      err_addr_q, err_addr_d;
    logic [CNT_W-1:0] ld_q, ld_d;
    logic [CNT_W-1:0] st_q, st_d;

    logic fault;
    logic load;
    logic bad_addr;

    always_comb begin
        bad_addr = (ex_alu_out[1:0] != 2'b00) || (ex_alu_out[31:12] != 20'd0) ||
                   (ex_memread && ex_memwrite);
        fault    = ex_valid && (ex_memread || ex_memwrite) && bad_addr;
        load     = !flush && !stall;
    end

    always_comb begin
        valid_d    = valid_q;
        alu_d      = alu_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        ld_d       = ld_q;
        st_d       = st_q;

        if (err_clr) begin
            err_d = 1'b0;
        end

        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
        end else if (load) begin
            valid_d    = ex_valid;
            alu_d      = ex_alu_out;
            wdata_d    = ex_wdata;
            rd_d       = ex_rd;
            // A bubble carries no control; a faulting access keeps only memtoreg.
            regwrite_d = ex_valid && ex_regwrite && !fault;
            memtoreg_d = ex_valid && ex_memtoreg;
            memread_d  = ex_valid && ex_memread && !fault;
            memwrite_d = ex_valid && ex_memwrite && !fault;

            if (ex_valid && !fault && ex_memread && (ld_q != '1)) begin
                ld_d = ld_q + CNT_W'(1);
            end
            if (ex_valid && !fault && ex_memwrite && (st_q != '1)) begin
                st_d = st_q + CNT_W'(1);
            end

            // A new fault beats a same-cycle clear and restarts the first-fault record.
            if (fault) begin
                if (!err_q || err_clr) begin
                    err_addr_d = ex_alu_out;
                end
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            alu_q      <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            ld_q       <= '0;
            st_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            alu_q      <= alu_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            ld_q       <= ld_d;
            st_q       <= st_d;
        end
    end

    always_comb begin
        dm_addr      = alu_q[11:2];
        dm_din       = wdata_q;
        dm_we        = valid_q && memwrite_q;
        mem_valid    = valid_q;
        mem_alu_out  = alu_q;
        mem_rd       = rd_q;
        mem_regwrite = regwrite_q;
        mem_memtoreg = memtoreg_q;
        mem_memread  = memread_q;
        err          = err_q;
        err_addr     = err_addr_q;
        ld_cnt       = ld_q;
        st_cnt       = st_q;
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_ex_mem_stage;

    localparam int unsigned CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall;
    logic             flush;
    logic             ex_valid;
    logic [31:0]      ex_alu_out;
    logic [31:0]      ex_wdata;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             ex_memwrite;
    logic             ex_regwrite;
    logic             ex_memtoreg;
    logic             err_clr;
    logic [9:0]       dm_addr;
    logic [31:0]      dm_din;
    logic             dm_we;
    logic             mem_valid;
    logic [31:0]      mem_alu_out;
    logic [4:0]       mem_rd;
    logic             mem_regwrite;
    logic             mem_memtoreg;
    logic             mem_memread;
    logic             err;
    logic [31:0]      err_addr;
    logic [CNT_W-1:0] ld_cnt;
    logic [CNT_W-1:0] st_cnt;

    ex_mem_stage #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_alu_out   (ex_alu_out),
        .ex_wdata     (ex_wdata),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .ex_memwrite  (ex_memwrite),
        .ex_regwrite  (ex_regwrite),
        .ex_memtoreg  (ex_memtoreg),
        .err_clr      (err_clr),
        .dm_addr      (dm_addr),
        .dm_din       (dm_din),
        .dm_we        (dm_we),
        .mem_valid    (mem_valid),
        .mem_alu_out  (mem_alu_out),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .mem_memtoreg (mem_memtoreg),
        .mem_memread  (mem_memread),
        .err          (err),
        .err_addr     (err_addr),
        .ld_cnt       (ld_cnt),
        .st_cnt       (st_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    // Reference state: what the stage should be presenting right now.
    bit          m_valid;
    bit          m_known;
    logic [31:0] m_alu;
    logic [31:0] m_wdata;
    logic [4:0]  m_rd;
    bit          m_rw, m_mtr, m_mr, m_mw;
    bit          m_err;
    logic [31:0] m_eaddr;
    int          m_ld, m_st;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Applies one rising edge of the specified behaviour to the reference state.
    task automatic model_edge();
        bit is_mem, bad, fault;
        if (!rst_n) begin
            m_valid = 0; m_known = 1; m_alu = 0; m_wdata = 0; m_rd = 0;
            m_rw = 0; m_mtr = 0; m_mr = 0; m_mw = 0;
            m_err = 0; m_eaddr = 0; m_ld = 0; m_st = 0;
            return;
        end
        if (err_clr) m_err = 0;
        if (flush) begin
            m_valid = 0; m_known = 0;
            m_rw = 0; m_mtr = 0; m_mr = 0; m_mw = 0;
        end else if (!stall) begin
            is_mem = ex_memread || ex_memwrite;
            bad    = (ex_alu_out % 4 != 0) || (ex_alu_out >= 32'd4096) ||
                     (ex_memread && ex_memwrite);
            fault  = ex_valid && is_mem && bad;
            m_valid = ex_valid; m_known = 1;
            m_alu = ex_alu_out; m_wdata = ex_wdata; m_rd = ex_rd;
            m_rw  = ex_valid && ex_regwrite && !fault;
            m_mtr = ex_valid && ex_memtoreg;
            m_mr  = ex_valid && ex_memread && !fault;
            m_mw  = ex_valid && ex_memwrite && !fault;
            if (m_mr && m_ld < CNT_MAX) m_ld++;
            if (m_mw && m_st < CNT_MAX) m_st++;
            if (fault) begin
                if (!m_err || err_clr) m_eaddr = ex_alu_out;
                m_err = 1;
            end
        end
    endtask

    task automatic check_all();
        check("mem_valid", 32'(mem_valid), 32'(m_valid));
        check("dm_we", 32'(dm_we), 32'(m_valid && m_mw));
        if (m_known) begin
            check("mem_alu_out", mem_alu_out, m_alu);
            check("dm_addr", 32'(dm_addr), m_alu / 4 % 1024);
            check("dm_din", dm_din, m_wdata);
            check("mem_rd", 32'(mem_rd), 32'(m_rd));
        end
        if (m_valid) begin
            check("mem_regwrite", 32'(mem_regwrite), 32'(m_rw));
            check("mem_memtoreg", 32'(mem_memtoreg), 32'(m_mtr));
            check("mem_memread", 32'(mem_memread), 32'(m_mr));
        end
        check("err", 32'(err), 32'(m_err));
        check("err_addr", err_addr, m_eaddr);
        check("ld_cnt", 32'(ld_cnt), 32'(m_ld));
        check("st_cnt", 32'(st_cnt), 32'(m_st));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input bit mr, input bit mw, input bit rw,
                         input bit mtr);
        ex_valid = v; ex_alu_out = a; ex_wdata = d; ex_rd = rd;
        ex_memread = mr; ex_memwrite = mw; ex_regwrite = rw; ex_memtoreg = mtr;
    endtask

    task automatic bubble();
        drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    endtask

    task automatic randomize_ex();
        logic [31:0] a;
        case ($urandom_range(0, 3))
            0, 1:    a = {20'd0, 10'($urandom), 2'b00};
            2:       a = {20'd0, 12'($urandom)};
            default: a = $urandom;
        endcase
        drive($urandom_range(0, 9) != 0, a, $urandom, 5'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    int st_before;

    initial begin
        rst_n = 0; stall = 0; flush = 0; err_clr = 0;
        bubble();
        #1;

        // Reset with random inputs on every control.
        for (int i = 0; i < 2; i++) begin
            randomize_ex();
            stall = 1'($urandom); flush = 1'($urandom); err_clr = 1'($urandom);
            step();
        end
        check("rst mem_valid", 32'(mem_valid), 32'd0);
        check("rst mem_alu_out", mem_alu_out, 32'd0);
        check("rst err_addr", err_addr, 32'd0);
        @(negedge clk);
        check("rst dm_we negedge", 32'(dm_we), 32'd0);
        #1;
        rst_n = 1; stall = 0; flush = 0; err_clr = 0;
        bubble();
        step();

        // Aligned store then load.
        drive(1, 32'h10, 32'hDEAD_BEEF, 5'd0, 0, 1, 0, 0);
        step();
        check("sw dm_addr", 32'(dm_addr), 32'h004);
        check("sw dm_we", 32'(dm_we), 32'd1);
        check("sw dm_din", dm_din, 32'hDEAD_BEEF);
        drive(1, 32'h10, 32'h0, 5'd5, 1, 0, 1, 1);
        step();
        check("lw dm_we", 32'(dm_we), 32'd0);
        check("lw mem_memread", 32'(mem_memread), 32'd1);
        bubble();
        step();
        check("st_cnt after sw", 32'(st_cnt), 32'd1);
        check("ld_cnt after lw", 32'(ld_cnt), 32'd1);

        // Fault cases.
        drive(1, 32'h12, 32'h1234_5678, 5'd0, 0, 1, 0, 0);
        step();
        check("mis sw dm_we", 32'(dm_we), 32'd0);
        check("mis sw err", 32'(err), 32'd1);
        check("mis sw err_addr", err_addr, 32'h12);
        drive(1, 32'h1000, 32'h0, 5'd7, 1, 0, 1, 1);
        step();
        check("oor lw regwrite", 32'(mem_regwrite), 32'd0);
        check("oor lw err_addr", err_addr, 32'h12);
        drive(1, 32'h3, 32'h0, 5'd8, 1, 0, 1, 1);
        err_clr = 1;
        step();
        err_clr = 0;
        check("clr+fault err", 32'(err), 32'd1);
        check("clr+fault err_addr", err_addr, 32'h3);
        err_clr = 1;
        bubble();
        step();
        err_clr = 0;
        check("clr err", 32'(err), 32'd0);

        // Store held by stall, then flush+stall.
        st_before = m_st;
        drive(1, 32'h20, 32'hCAFE_F00D, 5'd0, 0, 1, 0, 0);
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_ex();
            step();
            check("stall dm_we", 32'(dm_we), 32'd1);
            check("stall dm_addr", 32'(dm_addr), 32'h008);
            check("stall dm_din", dm_din, 32'hCAFE_F00D);
        end
        check("stall st_cnt once", 32'(st_cnt), 32'(st_before + 1));
        flush = 1;
        step();
        check("flush mem_valid", 32'(mem_valid), 32'd0);
        check("flush dm_we", 32'(dm_we), 32'd0);
        flush = 0; stall = 0;

        // Load counter saturation from zero.
        rst_n = 0;
        bubble();
        step();
        rst_n = 1;
        for (int i = 1; i <= 17; i++) begin
            drive(1, {20'd0, 10'($urandom), 2'b00}, 32'h0, 5'd1, 1, 0, 1, 1);
            step();
            if (i == 15) check("ld_cnt reaches max", 32'(ld_cnt), 32'hF);
        end
        check("ld_cnt saturated", 32'(ld_cnt), 32'hF);

        // Reset while a store is resident under stall.
        drive(1, 32'h40, 32'h5555_AAAA, 5'd0, 0, 1, 0, 0);
        step();
        stall = 1; rst_n = 0;
        step();
        check("rst-stall dm_we", 32'(dm_we), 32'd0);
        check("rst-stall ld_cnt", 32'(ld_cnt), 32'd0);
        check("rst-stall st_cnt", 32'(st_cnt), 32'd0);
        rst_n = 1; stall = 0;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            randomize_ex();
            stall   = $urandom_range(0, 4) == 0;
            flush   = $urandom_range(0, 9) == 0;
            err_clr = $urandom_range(0, 7) == 0;
            rst_n   = $urandom_range(0, 49) != 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
